// File: rtl/psum_drain.sv
// Drain stage below a PE-column accumulator: counts accumulation steps, captures
// the finished partial sum into a small FIFO and streams it out via valid/ready.
module psum_drain #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic                         i_clr,
    input  logic [CNTW-1:0]              i_len,
    input  logic signed [WIDTH-1:0]      i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [WIDTH-1:0]      o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_cnt,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_ovf
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);

    logic [CNTW-1:0]  k_q, k_d;
    logic [CNTW-1:0]  len_m1;
    logic             cap_pend_q, cap_pend_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;
    logic             push_drop;

    // Step counter: clear wins over enable, mirroring the accumulator. Using >=
    // lets a shortened i_len mid-tile capture on the very next enabled step.
    always_comb begin
        len_m1     = (i_len == '0) ? '0 : i_len - CNTW'(1);
        k_d        = k_q;
        cap_pend_d = 1'b0;
        if (i_clr) begin
            k_d = '0;
        end else if (i_en) begin
            if (k_q >= len_m1) begin
                k_d        = '0;
                cap_pend_d = 1'b1;
            end else begin
                k_d = k_q + CNTW'(1);
            end
        end
    end

    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign pop        = !fifo_empty && i_ready;
    assign push_ok    = cap_pend_q && (!fifo_full || pop);
    assign push_drop  = cap_pend_q && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
        ovf_d    = ovf_q | push_drop;
        cnt_d    = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_data;
        end
    end

    // Storage carries no reset; the empty gate on o_data hides stale entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            cap_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            k_q        <= k_d;
            cap_pend_q <= cap_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_valid = !fifo_empty;
    assign o_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign o_cnt   = cnt_q;
    assign o_full  = fifo_full;
    assign o_empty = fifo_empty;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: table of per-cycle vectors plus hand sequences
// for reset-with-pending-capture and a stalled stream over 10 L=1 captures.
module tb_psum_drain;

    localparam int WIDTH = 24;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             i_en;
    logic             i_clr;
    logic [CNTW-1:0]  i_len;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [CW-1:0]    o_cnt;
    logic             o_full;
    logic             o_empty;
    logic             o_ovf;

    int checks = 0;
    int errors = 0;

    psum_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_en    (i_en),
        .i_clr   (i_clr),
        .i_len   (i_len),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_cnt   (o_cnt),
        .o_full  (o_full),
        .o_empty (o_empty),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic             clr;
        logic [CNTW-1:0]  len;
        logic [WIDTH-1:0] data;
        logic             ready;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic [CW-1:0]    exp_cnt;
        logic             exp_ovf;
    } vec_t;

    localparam int NVEC = 35;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic en, logic clr, int len, logic [WIDTH-1:0] data,
                                logic ready, logic ev, logic [WIDTH-1:0] ed, int ec, logic eovf);
        vec_t v;
        v.en = en; v.clr = clr; v.len = CNTW'(len); v.data = data; v.ready = ready;
        v.exp_valid = ev; v.exp_data = ed; v.exp_cnt = CW'(ec); v.exp_ovf = eovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [WIDTH-1:0] ed,
                              input logic [CW-1:0] ec, input logic eovf);
        chk({tag, ".valid"}, 32'(o_valid), 32'(ev));
        chk({tag, ".data"},  32'(o_data),  32'(ed));
        chk({tag, ".cnt"},   32'(o_cnt),   32'(ec));
        chk({tag, ".full"},  32'(o_full),  32'(ec == CW'(DEPTH)));
        chk({tag, ".empty"}, 32'(o_empty), 32'(ec == '0));
        chk({tag, ".ovf"},   32'(o_ovf),   32'(eovf));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] got [$];
        logic [WIDTH-1:0] held;
        logic             stalled;

        // L=3 tile: sums 5, 12, -7; one output of -7 for one cycle.
        tbl[0]  = mk(1, 0, 3, 24'd0,       1, 0, 24'd0,       0, 0);
        tbl[1]  = mk(1, 0, 3, 24'd5,       1, 0, 24'd0,       0, 0);
        tbl[2]  = mk(1, 0, 3, 24'd12,      1, 0, 24'd0,       0, 0);
        tbl[3]  = mk(0, 0, 3, 24'hFFFFF9,  1, 1, 24'hFFFFF9,  1, 0);
        tbl[4]  = mk(0, 0, 3, 24'hFFFFF9,  1, 0, 24'd0,       0, 0);
        tbl[5]  = mk(0, 0, 3, 24'd0,       1, 0, 24'd0,       0, 0);
        // i_len=0 acts as L=1: fill to 4, overflow drop, then full push with pop.
        tbl[6]  = mk(1, 0, 0, 24'd100,     0, 0, 24'd0,       0, 0);
        tbl[7]  = mk(1, 0, 0, 24'd101,     0, 1, 24'd101,     1, 0);
        tbl[8]  = mk(1, 0, 0, 24'd102,     0, 1, 24'd101,     2, 0);
        tbl[9]  = mk(1, 0, 0, 24'd103,     0, 1, 24'd101,     3, 0);
        tbl[10] = mk(0, 0, 0, 24'd104,     0, 1, 24'd101,     4, 0);
        tbl[11] = mk(1, 0, 0, 24'd0,       0, 1, 24'd101,     4, 0);
        tbl[12] = mk(0, 0, 0, 24'd555,     0, 1, 24'd101,     4, 1);
        tbl[13] = mk(1, 0, 0, 24'd0,       0, 1, 24'd101,     4, 1);
        tbl[14] = mk(0, 0, 0, 24'd200,     1, 1, 24'd102,     4, 1);
        tbl[15] = mk(0, 0, 0, 24'd0,       1, 1, 24'd103,     3, 1);
        tbl[16] = mk(0, 0, 0, 24'd0,       1, 1, 24'd104,     2, 1);
        tbl[17] = mk(0, 0, 0, 24'd0,       1, 1, 24'd200,     1, 1);
        tbl[18] = mk(0, 0, 0, 24'd0,       1, 0, 24'd0,       0, 1);
        // L=2: clear alongside pending capture keeps pre-clear sum.
        tbl[19] = mk(1, 0, 2, 24'd0,       1, 0, 24'd0,       0, 1);
        tbl[20] = mk(1, 0, 2, 24'd7,       1, 0, 24'd0,       0, 1);
        tbl[21] = mk(0, 1, 2, 24'd9,       1, 1, 24'd9,       1, 1);
        tbl[22] = mk(0, 0, 2, 24'd0,       1, 0, 24'd0,       0, 1);
        // Clear (with enable) after one step: no capture; two more steps capture.
        tbl[23] = mk(1, 0, 2, 24'd0,       1, 0, 24'd0,       0, 1);
        tbl[24] = mk(1, 1, 2, 24'd33,      1, 0, 24'd0,       0, 1);
        tbl[25] = mk(0, 0, 2, 24'd33,      1, 0, 24'd0,       0, 1);
        tbl[26] = mk(1, 0, 2, 24'd0,       1, 0, 24'd0,       0, 1);
        tbl[27] = mk(1, 0, 2, 24'd0,       1, 0, 24'd0,       0, 1);
        tbl[28] = mk(0, 0, 2, 24'd44,      1, 1, 24'd44,      1, 1);
        tbl[29] = mk(0, 0, 2, 24'd0,       1, 0, 24'd0,       0, 1);
        // i_len shortened from 4 to 2 with k already at 2: next enable captures.
        tbl[30] = mk(1, 0, 4, 24'd0,       1, 0, 24'd0,       0, 1);
        tbl[31] = mk(1, 0, 4, 24'd0,       1, 0, 24'd0,       0, 1);
        tbl[32] = mk(1, 0, 2, 24'd0,       1, 0, 24'd0,       0, 1);
        tbl[33] = mk(0, 0, 2, 24'd66,      1, 1, 24'd66,      1, 1);
        tbl[34] = mk(0, 0, 2, 24'd0,       1, 0, 24'd0,       0, 1);

        rst = 1'b1; i_en = 1'b0; i_clr = 1'b0; i_len = '0; i_data = '0; i_ready = 1'b0;
        step();
        step();
        check_outs("reset", 1'b0, '0, '0, 1'b0);
        $display("txn reset: valid=%0d cnt=%0d ovf=%0d", o_valid, o_cnt, o_ovf);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            i_en = tbl[i].en; i_clr = tbl[i].clr; i_len = tbl[i].len;
            i_data = tbl[i].data; i_ready = tbl[i].ready;
            step();
            check_outs($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_data,
                       tbl[i].exp_cnt, tbl[i].exp_ovf);
            $display("txn row%0d: en=%0d clr=%0d len=%0d din=%0h rdy=%0d -> valid=%0d dout=%0h cnt=%0d ovf=%0d",
                     i, i_en, i_clr, i_len, i_data, i_ready, o_valid, o_data, o_cnt, o_ovf);
        end

        // Reset while cnt=3 and a capture is pending.
        i_len = 8'd1; i_ready = 1'b0; i_clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            i_en = 1'b1; i_data = WIDTH'(300 + c);
            step();
        end
        chk("pre_rst.cnt",  32'(o_cnt),  32'd3);
        chk("pre_rst.data", 32'(o_data), 32'd301);
        chk("pre_rst.ovf",  32'(o_ovf),  32'd1);
        rst = 1'b1; i_en = 1'b0; i_data = WIDTH'(777);
        step();
        check_outs("rst_mid", 1'b0, '0, '0, 1'b0);
        $display("txn rst_mid: valid=%0d cnt=%0d ovf=%0d", o_valid, o_cnt, o_ovf);
        rst = 1'b0; i_data = WIDTH'(888);
        for (int c = 0; c < 3; c++) begin
            step();
            check_outs($sformatf("post_rst%0d", c), 1'b0, '0, '0, 1'b0);
        end

        // L=1 captures every other cycle, ready toggling: order and stall stability.
        i_len = 8'd1;
        for (int c = 0; c < 40; c++) begin
            i_en    = (c < 20) && (c % 2 == 0);
            i_data  = WIDTH'(1000 + c);
            i_ready = (c % 2 == 1);
            stalled = 1'b0;
            held    = o_data;
            if (o_valid && i_ready) begin
                got.push_back(o_data);
                $display("txn stream pop: %0d", o_data);
            end
            if (o_valid && !i_ready) stalled = 1'b1;
            step();
            if (stalled) begin
                chk($sformatf("stall%0d.valid", c), 32'(o_valid), 32'd1);
                chk($sformatf("stall%0d.data", c),  32'(o_data),  32'(held));
            end
        end
        chk("stream.npop", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            chk($sformatf("stream.pop%0d", i), 32'(got[i]), 32'(1001 + 2 * i));
        end
        chk("stream.ovf", 32'(o_ovf), 32'd0);
        chk("stream.cnt", 32'(o_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
# psum_drain

Output drain stage that sits directly downstream of the binary-parallel accumulator at the bottom of each PE column. It counts accumulation steps, captures the accumulator's finished partial sum once a programmed number of steps has completed, and buffers results in a small FIFO. Results leave through a valid/ready stream toward the output writeback path. Overflow is flagged and never silently corrupts buffered data.

## Interface
Parameters:
- WIDTH, 24, accumulator data width (signed)
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNTW, 8, width of step counter and `i_len`

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_en  in  1  accumulator enable for this cycle (same signal that drives the accumulator `en`)
- i_clr  in  1  accumulator clear for this cycle (same signal that drives the accumulator `clr`)
- i_len  in  CNTW  accumulation steps per output; must be held stable while a tile is in progress
- i_data  in  WIDTH  signed; the accumulator's registered output
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accept
- o_data  out  WIDTH  signed; FIFO head
- o_cnt  out  $clog2(DEPTH+1)  FIFO occupancy
- o_full  out  1  occupancy == DEPTH
- o_empty  out  1  occupancy == 0
- o_ovf  out  1  sticky; a capture was dropped

## Operation
- Effective length: L = `i_len`, except `i_len` = 0 is treated as 1.
- Step counter `k`:
  - Resets to 0.
  - On an edge with `i_en`=1 and `i_clr`=0: if k == L-1, then k <= 0 and `cap_pend` <= 1; otherwise k <= k+1.
  - On an edge with `i_clr`=1, k <= 0. `i_clr` has priority over `i_en`, matching the accumulator.
- `cap_pend` is a one-cycle pulse; it is cleared on the following edge unless it is re-set.
- While `cap_pend`=1, `i_data` already holds the final sum. On that edge, `i_data` is pushed into the FIFO.
- A `cap_pend` push is NOT cancelled by `i_clr` asserted in the same cycle. The accumulator clears on that edge, after its old value has been sampled.
- Pop: an edge with `o_valid`=1 and `i_ready`=1.
- Push while full:
  - Without a simultaneous pop: the data is dropped, FIFO contents are unchanged, and `o_ovf` <= 1.
  - With a simultaneous pop: the push is accepted and occupancy is unchanged.
- `o_ovf` clears only on `rst`.
- FIFO ordering: strict FIFO. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked separately in `o_cnt`.
- Output stream:
  - `o_valid` = !`o_empty`.
  - `o_data` = head entry, driven from storage (first-word fall-through). `o_data` is 0 while empty.
- Data is stored bit-exact; there is no arithmetic on the data path.

## Timing
- Reset values:
  - `o_valid`=0, `o_data`=0, `o_cnt`=0, `o_full`=0, `o_empty`=1, `o_ovf`=0.
  - k=0, `cap_pend`=0, both pointers 0.
- Capture latency: final `i_en` sampled at edge E → accumulator updates at E → `cap_pend` high after E → push at E+1 → `o_valid` high after E+1 (when the FIFO was empty).
- `o_data` changes only on the edge after a pop, or on the first push into an empty FIFO. It holds stable while `o_valid`=1 and `i_ready`=0.
- Back-to-back tiles with L=1 push on every cycle. Throughput is 1 result/cycle when `i_ready` is held high.
- Simultaneous push and pop on an empty FIFO: no pop occurs (`o_valid`=0), the push lands, and `o_cnt` becomes 1.
- `rst` asserted mid-tile or while `cap_pend`=1: everything returns to reset values on that edge, and the pending capture is lost.
- `i_len` changed mid-tile: the comparison uses the new value from the next edge. If k ≥ new L-1, the next `i_en` captures and wraps k to 0.

## Test plan
- L=3, `i_en` high for 3 cycles with accumulator sums 5, 12, -7 (`i_data` = -7 after the third edge), `i_ready`=1 → exactly one output, `o_data`=-7 (0xFFFFF9), `o_valid` high 2 cycles after the last `i_en` cycle, high for 1 cycle.
- `i_len`=0 with `i_en` held high for 4 cycles and `i_ready`=0 → 4 pushes, `o_cnt`=4, `o_full`=1, FIFO order preserved on later drain.
- DEPTH=4 full, `i_ready`=0, one more capture → `o_ovf`=1 and stays set; drain yields the original 4 values. Repeat with `i_ready`=1 on the capture edge → no overflow, `o_cnt` stays 4.
- L=2: `i_clr` asserted on the same cycle `cap_pend` is high → the pushed value is the pre-clear sum. `i_clr` after 1 of 2 steps → no push, and 2 further `i_en` produce one push.
- `i_ready` toggling 1/0 on alternate cycles over 10 captures with L=1 → output sequence equals input sequence, `o_data` stable while stalled, pointer wrap exercised.
- `rst` asserted for 1 cycle while `o_cnt`=3 and `cap_pend`=1 → all outputs at reset values on the next cycle, no stale push afterwards.
